// File: rtl/vga_pkg.sv
// vga_pkg: shared framebuffer geometry, pattern codes and the pattern-writer state encoding
package vga_pkg;
    localparam int H_PIXELS    = 128;
    localparam int V_PIXELS    = 96;
    localparam int HADDR_W     = 7;
    localparam int VADDR_W     = 7;
    localparam int VRAM_ADDR_W = 14;
    localparam int COLOUR_W    = 3;
    localparam logic [1:0] PAT_SOLID   = 2'd0;
    localparam logic [1:0] PAT_VBARS   = 2'd1;
    localparam logic [1:0] PAT_HBARS   = 2'd2;
    localparam logic [1:0] PAT_CHECKER = 2'd3;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_VB, ST_WRITE, ST_DONE} wr_state_t;
endpackage

// File: rtl/vram_pattern_writer_if.sv
// vram_pattern_writer_if: fill-request handshake plus the VRAM write port of the pattern writer
interface vram_pattern_writer_if;
    import vga_pkg::*;
    logic                   start;
    logic [1:0]             pattern_sel;
    logic [COLOUR_W-1:0]    colour_in;
    logic                   vblank;
    logic                   vram_we;
    logic [VRAM_ADDR_W-1:0] vram_waddr;
    logic [COLOUR_W-1:0]    vram_wdata;
    logic                   busy;
    logic                   done;
    modport master (
        output start, pattern_sel, colour_in, vblank,
        input  vram_we, vram_waddr, vram_wdata, busy, done
    );
    modport slave (
        input  start, pattern_sel, colour_in, vblank,
        output vram_we, vram_waddr, vram_wdata, busy, done
    );
endinterface

// File: rtl/vram_pattern_colour.sv
// vram_pattern_colour: combinational test-pattern colour for one framebuffer location
module vram_pattern_colour
    import vga_pkg::*;
(
    input  logic [VADDR_W-1:0]  row,
    input  logic [HADDR_W-1:0]  col,
    input  logic [1:0]          pattern,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [COLOUR_W-1:0] colour
);
    logic odd;
    always_comb begin
        odd = 1'((col ^ row) >> 3);
        colour = colour_in;
        case (pattern)
            PAT_SOLID:   colour = colour_in;
            PAT_VBARS:   colour = 3'(col >> 4);
            PAT_HBARS:   colour = 3'(row >> 4);
            PAT_CHECKER: colour = odd ? ~colour_in : colour_in;
        endcase
    end
endmodule

// File: rtl/vram_pattern_writer.sv
// vram_pattern_writer: sweeps the visible 128x96 framebuffer once per start, one pattern write per clock
module vram_pattern_writer #(
    parameter int H_PIXELS    = vga_pkg::H_PIXELS,
    parameter int V_PIXELS    = vga_pkg::V_PIXELS,
    parameter bit WAIT_VBLANK = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    vram_pattern_writer_if.slave bus
);
    import vga_pkg::*;
    wr_state_t           state, state_n;
    logic [VADDR_W-1:0]  row, row_n;
    logic [HADDR_W-1:0]  col, col_n;
    logic [1:0]          pat_q, pat_n;
    logic [COLOUR_W-1:0] base_q, base_n, pix;
    logic                row_end, frame_end;
    assign row_end   = col == HADDR_W'(H_PIXELS - 1);
    assign frame_end = row_end && row == VADDR_W'(V_PIXELS - 1);
    vram_pattern_colour u_colour (
        .row      (row_n),
        .col      (col_n),
        .pattern  (pat_n),
        .colour_in(base_n),
        .colour   (pix)
    );
    // row/col always name the pixel being written in the current WRITE cycle
    always_comb begin
        state_n = state;
        row_n = row;
        col_n = col;
        pat_n = pat_q;
        base_n = base_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n = WAIT_VBLANK ? ST_WAIT_VB : ST_WRITE;
                    pat_n = bus.pattern_sel;
                    base_n = bus.colour_in;
                end
            end
            ST_WAIT_VB: state_n = bus.vblank ? ST_WRITE : ST_WAIT_VB;
            ST_WRITE: begin
                state_n = frame_end ? ST_DONE : ST_WRITE;
                col_n = row_end ? '0 : col + 1'b1;
                row_n = frame_end ? '0 : row_end ? row + 1'b1 : row;
            end
            default: state_n = ST_IDLE;
        endcase
    end
    // outputs are registered from next-state values so the first write lands the cycle after acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            row <= '0;
            col <= '0;
            pat_q <= '0;
            base_q <= '0;
            bus.vram_we <= 1'b0;
            bus.vram_waddr <= '0;
            bus.vram_wdata <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state <= state_n;
            row <= row_n;
            col <= col_n;
            pat_q <= pat_n;
            base_q <= base_n;
            bus.vram_we <= state_n == ST_WRITE;
            bus.vram_waddr <= state_n == ST_WRITE ? {row_n, col_n} : '0;
            bus.vram_wdata <= state_n == ST_WRITE ? pix : '0;
            bus.busy <= state_n == ST_WAIT_VB || state_n == ST_WRITE;
            bus.done <= state_n == ST_DONE;
        end
    end
endmodule

// File: tb/tb_vram_pattern_writer.sv
// tb_vram_pattern_writer: scoreboard bench driving one immediate-start and one vblank-gated writer
module tb_vram_pattern_writer;
    import vga_pkg::*;
    typedef struct {
        int          cyc;
        bit          dn;
        logic [13:0] addr;
        logic [2:0]  data;
    } exp_t;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic [2:0] mem0 [16384];
    logic [2:0] mem1 [16384];

    vram_pattern_writer_if b0();
    vram_pattern_writer_if b1();
    vram_pattern_writer #(.WAIT_VBLANK(1'b0)) dut0 (.clk(clk), .reset(rst0), .bus(b0));
    vram_pattern_writer #(.WAIT_VBLANK(1'b1)) dut1 (.clk(clk), .reset(rst1), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [2:0] model(input logic [1:0] p, input logic [2:0] c, input int r, input int x);
        case (p)
            2'd0:    return c;
            2'd1:    return 3'(x / 16);
            2'd2:    return 3'(r / 16);
            default: return ((x / 8 + r / 8) % 2 != 0) ? ~c : c;
        endcase
    endfunction

    task automatic expect_fill(input int which, input int a, input logic [1:0] p, input logic [2:0] c);
        exp_t e;
        for (int r = 0; r < 96; r++) begin
            for (int x = 0; x < 128; x++) begin
                e = '{a + r * 128 + x, 1'b0, 14'(r * 128 + x), model(p, c, r, x)};
                if (which == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
        e = '{a + 12288, 1'b1, 14'd0, 3'd0};
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic drain(input int which, input string nm);
        int n = 0;
        while ((which == 0 ? q0.size() : q1.size()) != 0 && n < 13000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(which == 0 ? q0.size() : q1.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (b0.vram_we) mem0[b0.vram_waddr] = b0.vram_wdata;
        if (q0.size() != 0 && q0[0].cyc == cyc) begin
            e0 = q0.pop_front();
            if (e0.dn) chk("dut0 done {we,done,busy}", 32'({b0.vram_we, b0.done, b0.busy}), 32'(3'b010));
            else chk("dut0 write {we,done,busy,addr,data}",
                     32'({b0.vram_we, b0.done, b0.busy, b0.vram_waddr, b0.vram_wdata}),
                     32'({3'b101, e0.addr, e0.data}));
        end else if (b0.vram_we || b0.done) begin
            chk("dut0 unexpected {we,done}", 32'({b0.vram_we, b0.done}), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (b1.vram_we) mem1[b1.vram_waddr] = b1.vram_wdata;
        if (q1.size() != 0 && q1[0].cyc == cyc) begin
            e1 = q1.pop_front();
            if (e1.dn) chk("dut1 done {we,done,busy}", 32'({b1.vram_we, b1.done, b1.busy}), 32'(3'b010));
            else chk("dut1 write {we,done,busy,addr,data}",
                     32'({b1.vram_we, b1.done, b1.busy, b1.vram_waddr, b1.vram_wdata}),
                     32'({3'b101, e1.addr, e1.data}));
        end else if (b1.vram_we || b1.done) begin
            chk("dut1 unexpected {we,done}", 32'({b1.vram_we, b1.done}), 32'd0);
        end
    end

    task automatic start0(input logic [1:0] p, input logic [2:0] c);
        @(negedge clk);
        b0.start = 1'b1;
        b0.pattern_sel = p;
        b0.colour_in = c;
        expect_fill(0, cyc + 1, p, c);
        @(negedge clk);
        b0.start = 1'b0;
    endtask

    task automatic seq0();
        repeat (3) @(negedge clk);
        chk("dut0 reset outputs", 32'({b0.vram_we, b0.done, b0.busy, b0.vram_waddr, b0.vram_wdata}), 32'd0);
        rst0 = 1'b0;
        start0(PAT_SOLID, 3'b100);
        drain(0, "dut0 solid drain");
        chk("solid busy after done", 32'(b0.busy), 32'd0);
        chk("solid {0,0}", 32'(mem0[14'h0000]), 32'(3'b100));
        chk("solid {95,127}", 32'(mem0[14'h2FFF]), 32'(3'b100));
        chk("row 96 untouched", 32'(mem0[14'h3000]), 32'd0);
        chk("row 127 untouched", 32'(mem0[14'h3FFF]), 32'd0);
        start0(PAT_HBARS, 3'b000);
        drain(0, "dut0 hbars drain");
        chk("hbars {15,0}", 32'(mem0[14'h0780]), 32'd0);
        chk("hbars {16,5}", 32'(mem0[14'h0805]), 32'd1);
        chk("hbars {95,127}", 32'(mem0[14'h2FFF]), 32'd5);
        start0(PAT_CHECKER, 3'b010);
        repeat (100) @(negedge clk);
        b0.start = 1'b1;
        b0.pattern_sel = PAT_SOLID;
        b0.colour_in = 3'b111;
        repeat (3) @(negedge clk);
        b0.start = 1'b0;
        drain(0, "dut0 checker drain");
        chk("checker {0,0}", 32'(mem0[14'h0000]), 32'(3'b010));
        chk("checker {0,8}", 32'(mem0[14'h0008]), 32'(3'b101));
        chk("checker {8,8}", 32'(mem0[14'h0408]), 32'(3'b010));
        chk("checker {8,0}", 32'(mem0[14'h0400]), 32'(3'b101));
        start0(PAT_SOLID, 3'b001);
        repeat (4999) @(negedge clk);
        #2;
        rst0 = 1'b1;
        #1;
        chk("async reset {we,busy,done}", 32'({b0.vram_we, b0.busy, b0.done}), 32'd0);
        q0.delete();
        @(negedge clk);
        rst0 = 1'b0;
        start0(PAT_VBARS, 3'b000);
        drain(0, "dut0 restart drain");
    endtask

    task automatic seq1();
        repeat (3) @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        b1.start = 1'b1;
        b1.pattern_sel = PAT_VBARS;
        b1.colour_in = 3'b011;
        @(negedge clk);
        b1.start = 1'b0;
        chk("wait_vb busy on entry", 32'(b1.busy), 32'd1);
        repeat (200) @(negedge clk);
        chk("wait_vb busy held", 32'(b1.busy), 32'd1);
        chk("wait_vb no write", 32'(b1.vram_we), 32'd0);
        b1.vblank = 1'b1;
        expect_fill(1, cyc + 1, PAT_VBARS, 3'b011);
        repeat (3) @(negedge clk);
        b1.vblank = 1'b0;
        drain(1, "dut1 vbars drain");
        chk("vbars {0,0}", 32'(mem1[14'h0000]), 32'd0);
        chk("vbars {0,15}", 32'(mem1[14'h000F]), 32'd0);
        chk("vbars {0,16}", 32'(mem1[14'h0010]), 32'd1);
        chk("vbars {50,127}", 32'(mem1[14'h197F]), 32'd7);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem0[i] = 3'd0;
            mem1[i] = 3'd0;
        end
        b0.start = 1'b0;
        b0.pattern_sel = 2'd0;
        b0.colour_in = 3'd0;
        b0.vblank = 1'b0;
        b1.start = 1'b0;
        b1.pattern_sel = 2'd0;
        b1.colour_in = 3'd0;
        b1.vblank = 1'b0;
        fork
            seq0();
            seq1();
        join
        chk("dut0 queue empty", 32'(q0.size()), 32'd0);
        chk("dut1 queue empty", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/vram_pattern_writer.md
Name: vram_pattern_writer

Overview:
- Upstream filler for the 128x96, 3-bit-colour video RAM that the VGA scan-out path reads.
- On a start request it sweeps every visible framebuffer location once and emits one write per clock with a generated test pattern.
- Optionally holds off the first write until vertical blanking, so a fill never begins mid-frame.
- Drives the VRAM write port: address {row[6:0], col[6:0]}, 3-bit data, write enable.

Parameters:
- H_PIXELS, 128, columns per row; column field is 7 bits.
- V_PIXELS, 96, rows per frame; row field is 7 bits.
- WAIT_VBLANK, 1, 1 = hold in WAIT_VB until vblank=1 before writing; 0 = write immediately.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  fill request, sampled only in IDLE
- pattern_sel  input  2  pattern code, latched on accepted start
- colour_in  input  3  base colour {R,G,B}, latched on accepted start
- vblank  input  1  high during vertical blanking (from the VSYNC timing FSM)
- vram_we  output  1  write enable to VRAM
- vram_waddr  output  14  write address {row, col}
- vram_wdata  output  3  write data {R,G,B}
- busy  output  1  high while a fill is pending or in progress
- done  output  1  one-cycle pulse after the final write

Behaviour:
- Reset (async, active-high): state=IDLE, row=0, col=0, latched pattern/colour=0; all outputs 0. VRAM contents are untouched.
- States:
  - IDLE: start=1 latches pattern_sel and colour_in. Next state is WAIT_VB if WAIT_VBLANK=1, else WRITE.
  - WAIT_VB: busy=1, vram_we=0. Move to WRITE on the first clock with vblank=1.
  - WRITE: vram_we=1, one pixel per clock.
  - DONE: done=1, busy=0 for one cycle, then IDLE.
- All outputs are registered.
- Latency, WAIT_VBLANK=0: start accepted at edge N → first write (addr 0x0000) in cycle N+1. Exactly 12288 consecutive write cycles follow. Last address is {95,127} = 0x2FFF. done pulses in cycle N+1+12288.
- Scan order: col increments 0..127. At col=127, col wraps to 0 and row increments. At {95,127}, go to DONE; row/col reset to 0.
- Addresses with row 96..127 are never written.
- busy is high from the cycle after acceptance through the last write cycle.
- vblank is ignored once WRITE has begun; a fill takes 12288 cycles and is never paused.
- start while not IDLE is ignored: no restart, no re-latch. Mid-fill changes to pattern_sel and colour_in have no effect.
- start held high continuously: after DONE→IDLE, the next accepted start is one cycle later.
- Pattern colour is a function of the current row/col and the latched values:
  - 0 SOLID: colour_in.
  - 1 VBARS: col[6:4], giving 8 bars of 16 px with values 0..7 left to right.
  - 2 HBARS: row[6:4], giving 6 bands of 16 rows with values 0..5.
  - 3 CHECKER: colour_in when col[3]^row[3]=0, else ~colour_in (8x8 squares).
- Reset mid-fill: immediate return to IDLE with vram_we=0. A partial frame remains in VRAM; no done pulse.

Decomposition:
- Shared package vga_pkg:
  - H_PIXELS=128, V_PIXELS=96, HADDR_W=7, VADDR_W=7, VRAM_ADDR_W=14, COLOUR_W=3.
  - Pattern codes PAT_SOLID=0, PAT_VBARS=1, PAT_HBARS=2, PAT_CHECKER=3.
  - Writer state encoding.
- One natural sub-module: vram_pattern_colour, purely combinational (row, col, pattern, colour_in → colour). It is reusable by a future on-the-fly pattern source in the scan-out path.

Test Plan:
- WAIT_VBLANK=0, start, SOLID, colour_in=3'b100 → 12288 writes, all wdata=100, addresses 0x0000..0x2FFF with none in 0x3000..0x3FFF, done pulse at cycle N+12289, busy low after.
- VBARS → wdata at {0,0}=0, {0,15}=0, {0,16}=1, {50,127}=7. HBARS → wdata at {15,x}=0, {16,x}=1, {95,x}=5.
- CHECKER, colour_in=3'b010 → {0,0}=010, {0,8}=101, {8,8}=010, {8,0}=101.
- WAIT_VBLANK=1, vblank=0 for 200 cycles after start → busy=1, no writes; vblank rises → first write the following cycle at 0x0000. Vblank dropping mid-fill → writes continue uninterrupted.
- start pulsed, and pattern_sel/colour_in changed, during WRITE → no restart, data unchanged, single done pulse.
- reset asserted at write 5000 → vram_we, busy and done go 0 immediately (async); a new start after release begins again at 0x0000.
